// File: rtl/mem_controller.sv
// Single memory-controller lane: pops requests, executes them on a local word memory, pushes responses.
// Optional macro MEM_CTRL_WRITE_ACK_EN: writes also return a {TID, written data} response.
module mem_controller #(
   parameter int MODULE_NUM   = 0,
   parameter int MODULE_WIDTH = 1,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 31,
   parameter int TID_WIDTH    = 16,
   parameter int MEM_AW       = 8
) (
   input  logic                                         clk,
   input  logic                                         reset,
   output logic                                         read_ctr,
   input  logic [TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH-1:0] incoming_data,
   input  logic                                         empty_signal,
   output logic                                         write_ctr,
   output logic [TID_WIDTH+DATA_WIDTH-1:0]              outgoing_data,
   input  logic                                         full_signal
);
   localparam int REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int RSP_W = TID_WIDTH + DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, RESP} state_t;

   state_t                 state_q, state_d;
   logic [REQ_W-1:0]       req_q, req_d;
   logic [RSP_W-1:0]       rsp_q, rsp_d;
   logic [DATA_WIDTH-1:0]  mem_q [2**MEM_AW];

   logic [TID_WIDTH-1:0]   req_tid;
   logic                   req_wr;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [DATA_WIDTH-1:0]  req_data;
   logic [ADDR_WIDTH-1:0]  word_addr;
   logic [MEM_AW-1:0]      mem_idx;
   logic                   mem_we;
   logic                   unused_ok;

   assign req_tid  = req_q[REQ_W-1 -: TID_WIDTH];
   assign req_wr   = req_q[ADDR_WIDTH+DATA_WIDTH];
   assign req_addr = req_q[DATA_WIDTH +: ADDR_WIDTH];
   assign req_data = req_q[DATA_WIDTH-1:0];

   // Lanes interleave on the address; upper word-address bits are dropped so accesses wrap.
   assign word_addr = req_addr / ADDR_WIDTH'(MODULE_WIDTH);
   assign mem_idx   = word_addr[MEM_AW-1:0];
   assign unused_ok = ^{word_addr[ADDR_WIDTH-1:MEM_AW], 32'(MODULE_NUM)};

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rsp_d     = rsp_q;
      mem_we    = 1'b0;
      read_ctr  = 1'b0;
      write_ctr = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_signal) state_d = FETCH;
         end
         FETCH: begin
            read_ctr = 1'b1;
            state_d  = LATCH;
         end
         LATCH: begin
            req_d   = incoming_data;
            state_d = EXEC;
         end
         EXEC: begin
            if (req_wr) begin
               mem_we  = 1'b1;
`ifdef MEM_CTRL_WRITE_ACK_EN
               rsp_d   = {req_tid, req_data};
               state_d = RESP;
`else
               state_d = IDLE;
`endif
            end else begin
               rsp_d   = {req_tid, mem_q[mem_idx]};
               state_d = RESP;
            end
         end
         RESP: begin
            // Push only when the response FIFO can take it; otherwise wait here.
            write_ctr = !full_signal;
            if (!full_signal) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_idx] <= req_data;
   end

   assign outgoing_data = rsp_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: two lanes (MODULE_WIDTH 1 and 2) share one request stream.
module tb_mem_controller;
   logic        clk;
   logic        reset;
   logic        empty_signal;
   logic        full_signal;
   logic [79:0] incoming_data;
   logic        rd1, wr1, rd2, wr2;
   logic [47:0] out1, out2;

   mem_controller #(.MODULE_NUM(0), .MODULE_WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .read_ctr(rd1), .incoming_data(incoming_data),
      .empty_signal(empty_signal), .write_ctr(wr1), .outgoing_data(out1), .full_signal(full_signal));

   mem_controller #(.MODULE_NUM(1), .MODULE_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .read_ctr(rd2), .incoming_data(incoming_data),
      .empty_signal(empty_signal), .write_ctr(wr2), .outgoing_data(out2), .full_signal(full_signal));

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          last_rd = 0;
   bit          bp = 0;
   logic [47:0] q1[$];
   logic [47:0] q2[$];
   logic [31:0] m1[256];
   logic [31:0] m2[256];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rd1) last_rd = cyc;
      if (wr1) begin
         check_eq("dut1 push pending", 64'(q1.size() > 0), 1);
         if (q1.size() > 0) check_eq("dut1 response", out1, q1.pop_front());
         if (!bp) check_eq("dut1 push latency", 64'(cyc - last_rd), 3);
      end
      if (wr2) begin
         check_eq("dut2 push pending", 64'(q2.size() > 0), 1);
         if (q2.size() > 0) check_eq("dut2 response", out2, q2.pop_front());
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] tid, input logic rw, input logic [30:0] addr,
                       input logic [31:0] data);
      int i1, i2;
      bit seen;
      seen = 0;
      i1 = int'(addr % 256);
      i2 = int'((addr / 2) % 256);
      if (rw) begin
         m1[i1] = data;
         m2[i2] = data;
`ifdef MEM_CTRL_WRITE_ACK_EN
         q1.push_back({tid, data});
         q2.push_back({tid, data});
`endif
      end else begin
         q1.push_back({tid, m1[i1]});
         q2.push_back({tid, m2[i2]});
      end
      empty_signal = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = rd1;
      end
      check_eq("fetch strobe", 64'(seen), 1);
      empty_signal = 1'b1;
      @(posedge clk);
      #1;
      check_eq("fetch pulse width", 64'(rd1), 0);
      incoming_data = {tid, rw, addr, data};
      @(posedge clk);
      #1;
      incoming_data = {80{1'b1}};
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [47:0] prev;
      clk = 0;
      reset = 0;
      empty_signal = 1;
      full_signal = 0;
      incoming_data = {80{1'b1}};

      // Reset state and quiet IDLE with an empty request FIFO.
      #1 reset = 1;
      #2;
      check_eq("reset read_ctr", 64'(rd1), 0);
      check_eq("reset write_ctr", 64'(wr1), 0);
      check_eq("reset outgoing dut1", out1, 0);
      check_eq("reset outgoing dut2", out2, 0);
      wait_cyc(2);
      reset = 0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (rd1) cnt++;
      end
      check_eq("idle read_ctr", 64'(cnt), 0);

      // Write then read the same address.
      wait_cyc(1);
      send(16'd1, 1'b1, 31'd5, 32'd15);
      wait_cyc(6);
`ifdef MEM_CTRL_WRITE_ACK_EN
      check_eq("write ack data", out1, 48'h0001_0000000F);
`endif
      send(16'd2, 1'b0, 31'd5, 32'd0);
      wait_cyc(6);
      check_eq("read after write", out1, 48'h0002_0000000F);

      // Write without ack leaves outgoing_data alone when the macro is off.
      prev = out1;
      send(16'd7, 1'b1, 31'd3, 32'd9);
      wait_cyc(6);
`ifndef MEM_CTRL_WRITE_ACK_EN
      check_eq("no-ack output held", out1, prev);
`endif
      send(16'd8, 1'b0, 31'd3, 32'd0);
      wait_cyc(6);
      check_eq("read tid8", out1, 48'h0008_00000009);

      // Backpressure: response held while full, then exactly one push.
      full_signal = 1;
      bp = 1;
      send(16'd9, 1'b0, 31'd5, 32'd0);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (wr1) cnt++;
      end
      check_eq("no push while full", 64'(cnt), 0);
      check_eq("held under backpressure", out1, 48'h0009_0000000F);
      @(posedge clk);
      #1 full_signal = 0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (wr1) cnt++;
      end
      check_eq("single push on release", 64'(cnt), 1);
      bp = 0;
      wait_cyc(1);

      // Address wrap and lane interleave.
      send(16'd10, 1'b1, 31'h202, 32'hA5A5_0001);
      wait_cyc(6);
      send(16'd11, 1'b0, 31'h002, 32'd0);
      wait_cyc(6);
      check_eq("wrap read dut1", out1, 48'h000B_A5A50001);
      check_eq("wrap read dut2", out2, 48'h000B_A5A50001);
      send(16'd12, 1'b1, 31'h003, 32'h3C3C_0002);
      wait_cyc(6);
      send(16'd13, 1'b0, 31'h002, 32'd0);
      wait_cyc(6);
      check_eq("interleave dut1", out1, 48'h000D_A5A50001);
      check_eq("interleave dut2", out2, 48'h000D_3C3C0002);

      // Reset during LATCH drops the request; the lane then restarts cleanly.
      empty_signal = 0;
      cnt = 0;
      for (int k = 0; k < 20 && cnt == 0; k++) begin
         @(negedge clk);
         if (rd1) cnt = 1;
      end
      check_eq("abort fetch strobe", 64'(cnt), 1);
      empty_signal = 1;
      @(posedge clk);
      #1;
      incoming_data = {16'd14, 1'b0, 31'd5, 32'd0};
      reset = 1;
      #1;
      check_eq("mid reset outgoing", out1, 0);
      check_eq("mid reset read_ctr", 64'(rd1), 0);
      wait_cyc(1);
      reset = 0;
      incoming_data = {80{1'b1}};
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (wr1) cnt++;
      end
      check_eq("no push after abort", 64'(cnt), 0);
      wait_cyc(1);
      send(16'd15, 1'b0, 31'd5, 32'd0);
      wait_cyc(6);
      check_eq("restart read", out1, 48'h000F_0000000F);

      check_eq("dut1 queue drained", 64'(q1.size()), 0);
      check_eq("dut2 queue drained", 64'(q2.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
